// File: rtl/decode_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// decode_hazard_ctrl
//
// Decode-stage sequencer for the 16-bit, 5-stage pipeline. The pipeline has
// no forwarding network, so a read of a register with a write still in flight
// must wait in decode until that write has retired.
//
// In-flight writes are tracked in a shift-register scoreboard. There is one
// slot per downstream stage (ID/EX, EX/MEM, MEM/WB), and slot 0 is the
// youngest. The scoreboard shifts on every unfrozen clock. The oldest slot
// retires on that shift, in the same cycle its write lands in the register
// file. Its dependency is therefore gone from the following cycle.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-low reset
//   id_valid    in   IF/ID holds a valid instruction
//   id_rs_sel   in   [2:0] read port 1 register
//   id_rs_used  in   instruction reads rs
//   id_rt_sel   in   [2:0] read port 2 register
//   id_rt_used  in   instruction reads rt
//   id_wr_en    in   instruction writes the register file
//   id_wr_sel   in   [2:0] resolved destination register
//   id_halt     in   instruction is HALT
//   br_taken    in   redirect resolved in execute (taken branch or jump)
//   mem_stall   in   memory busy; the whole pipeline freezes
//   stall_if    out  hold the PC and IF/ID
//   bubble_id   out  load a NOP into ID/EX
//   flush_if    out  squash IF/ID
//   halted      out  sticky halt indication
//   pend_cnt    out  number of valid scoreboard slots
//
// There are no valid/ready handshakes in this block. All controls are
// level-sensitive, evaluated every cycle, and combinational from the current
// state and inputs.
// -----------------------------------------------------------------------------
module decode_hazard_ctrl #(
  parameter int DEPTH     = 3,
  parameter int FLUSH_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [2:0]                 id_rs_sel,
  input  logic                       id_rs_used,
  input  logic [2:0]                 id_rt_sel,
  input  logic                       id_rt_used,
  input  logic                       id_wr_en,
  input  logic [2:0]                 id_wr_sel,
  input  logic                       id_halt,
  input  logic                       br_taken,
  input  logic                       mem_stall,
  output logic                       stall_if,
  output logic                       bubble_id,
  output logic                       flush_if,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt
);

  localparam int PW = $clog2(DEPTH + 1);
  // The counter only has to hold FLUSH_CYC-1. The redirect cycle itself is
  // the first flush cycle.
  localparam int FW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYC - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] slot_v;
  logic [2:0]       slot_reg [DEPTH];
  logic [FW-1:0]    flush_cnt;
  logic             halted_q;

  // ---------------------------------------------------------------------------
  // Dependency check
  // ---------------------------------------------------------------------------
  logic rs_match;
  logic rt_match;
  logic hazard;
  logic flushing;
  logic issue;
  logic halt_take;

  // All eight registers are real storage. r0 is matched like any other.
  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_v[i] && (slot_reg[i] == id_rs_sel)) rs_match = 1'b1;
      if (slot_v[i] && (slot_reg[i] == id_rt_sel)) rt_match = 1'b1;
    end
  end

  assign hazard   = id_valid & ((id_rs_used & rs_match) | (id_rt_used & rt_match));
  assign flushing = br_taken | (flush_cnt != '0);

  // An instruction leaves decode only if it is valid, has no outstanding
  // source dependency, is not being squashed, and the pipe is neither halted
  // nor frozen.
  assign issue     = id_valid & ~hazard & ~flushing & ~halted_q & ~mem_stall;

  // A HALT that arrives with a redirect is younger than the branch. It is
  // discarded with the rest of the wrong path.
  assign halt_take = id_valid & id_halt & ~hazard & ~flushing & ~mem_stall;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // A flush overrides a hazard stall. The dependent instruction is on the
  // wrong path and must be squashed, not held.
  assign stall_if  = mem_stall | halted_q | (hazard & ~flushing);
  // During a freeze ID/EX holds its contents, so no bubble is inserted.
  assign bubble_id = ~mem_stall & (hazard | flushing | halted_q | ~id_valid);
  assign flush_if  = flushing;
  assign halted    = halted_q;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt = pend_cnt + PW'(slot_v[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_v <= '0;
      for (int i = 0; i < DEPTH; i++) slot_reg[i] <= 3'd0;
    end else if (!mem_stall) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        slot_v[i]   <= slot_v[i-1];
        slot_reg[i] <= slot_reg[i-1];
      end
      // A bubble (issue=0) enters as an empty slot. This also covers the
      // case of a writer that is itself waiting on a hazard.
      slot_v[0]   <= issue & id_wr_en;
      slot_reg[0] <= id_wr_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Flush counter
  // ---------------------------------------------------------------------------
  // A redirect during an active flush reloads the counter rather than
  // adding to it. Only the newest redirect's wrong path needs squashing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (!mem_stall) begin
      if (br_taken) begin
        flush_cnt <= FLUSH_LOAD;
      end else if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky halt
  // ---------------------------------------------------------------------------
  // The halt flag clears only on reset. The scoreboard keeps shifting while
  // halted, so older writes still drain and pend_cnt falls to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (halt_take) begin
      halted_q <= 1'b1;
    end
  end

endmodule

// File: doc/decode_hazard_ctrl.md
Name: decode_hazard_ctrl

Overview:
- Sequences the decode stage of the 16-bit, 5-stage pipeline.
- Tracks in-flight register-file writes in a shift-register scoreboard and stalls decode on read-after-write dependencies. There is no forwarding network.
- Inserts bubbles into ID/EX, squashes IF/ID after taken branches or jumps, and latches halt.
- Sits beside the decode stage. Drives the PC and IF/ID hold/flush controls and the ID/EX NOP-insert control.

Parameters:
- DEPTH, 3, number of tracked in-flight stages (ID/EX, EX/MEM, MEM/WB).
- FLUSH_CYC, 2, number of cycles flush_if stays asserted after a redirect.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  IF/ID holds a valid instruction.
- id_rs_sel  in  3  read port 1 register (instr[10:8]).
- id_rs_used  in  1  the instruction reads rs.
- id_rt_sel  in  3  read port 2 register (instr[7:5]).
- id_rt_used  in  1  the instruction reads rt.
- id_wr_en  in  1  the decoded instruction writes the register file.
- id_wr_sel  in  3  resolved destination register (from RegDst, 3'b111 for link).
- id_halt  in  1  the decoded instruction is HALT.
- br_taken  in  1  redirect resolved in execute (branch taken or jump).
- mem_stall  in  1  data memory or cache busy; the whole pipeline freezes.
- stall_if  out  1  hold the PC and IF/ID.
- bubble_id  out  1  load a NOP into ID/EX.
- flush_if  out  1  squash IF/ID.
- halted  out  1  sticky halt indication.
- pend_cnt  out  $clog2(DEPTH+1)  number of valid scoreboard slots.

Behaviour:
- Scoreboard: DEPTH slots, each holding {v, reg[2:0]}. Slot 0 is the youngest.
- Shift rule: on every rising clk with mem_stall=0, slot[i] <= slot[i-1] and slot[0] <= {issue & id_wr_en, id_wr_sel}.
  - With mem_stall=1 all state holds. This covers the scoreboard, flush_cnt and halted.
  - The oldest slot retires on shift. Its write lands in the register file in that same cycle, so the dependency is cleared from the following cycle.
- match(r) = OR over i of (slot[i].v & slot[i].reg==r). All 8 registers are real, so r0 is matched like any other.
- hazard = id_valid & ((id_rs_used & match(id_rs_sel)) | (id_rt_used & match(id_rt_sel))). Combinational.
- flushing = br_taken | (flush_cnt != 0).
- issue = id_valid & ~hazard & ~flushing & ~halted & ~mem_stall.
- Outputs (all combinational from state and inputs):
  - stall_if = mem_stall | halted | (hazard & ~flushing).
  - bubble_id = ~mem_stall & (hazard | flushing | halted | ~id_valid).
  - flush_if = flushing.
  - pend_cnt = popcount of slot v bits.
- Flush counter:
  - On br_taken with mem_stall=0, flush_cnt <= FLUSH_CYC-1. The cycle in which br_taken is asserted counts as the first flush cycle.
  - Otherwise, with flush_cnt != 0 and mem_stall=0, flush_cnt decrements.
  - br_taken during an active flush reloads the counter. It does not extend by summing.
- Halt:
  - halted <= 1 when id_valid & id_halt & ~hazard & ~flushing & ~mem_stall.
  - It clears only on reset.
  - After halt the scoreboard keeps draining, so pend_cnt falls to 0.
- Simultaneous events:
  - br_taken with a hazard: flush wins. stall_if=0, flush_if=1, bubble_id=1.
  - br_taken with id_halt: the halt is younger than the branch and is discarded, so halted stays 0.
  - mem_stall with anything: freeze. stall_if=1, bubble_id=0, no state change.
  - id_wr_en with a hazard: no slot is written (issue=0).
- Reset (rst=0, asynchronous): all slot v bits=0, flush_cnt=0, halted=0.
  - Outputs while in reset: pend_cnt=0, halted=0, flush_if=br_taken.
  - Reset asserted mid-flush or mid-stall discards all pending state immediately.

Test Plan:
- Reset release, id_valid=1, no reads or writes → stall_if=0, bubble_id=0, flush_if=0, pend_cnt=0.
- RAW hazard: issue a write to r3, then next cycle an instruction reading rs=r3 → stall_if=1 and bubble_id=1 for exactly 3 cycles, then issue; pend_cnt goes 1,1,1,0 (slot[0] is empty after each bubble).
- br_taken pulse with FLUSH_CYC=2 → flush_if=1 for 2 cycles; a dependent instruction in IF/ID is not stalled; then normal issue resumes.
- mem_stall held for 4 cycles with 2 pending writes → pend_cnt stays 2, stall_if=1, bubble_id=0; after release, the shifting resumes.
- id_halt issued → halted=1 the next cycle; stall_if=1 persists; pend_cnt drains to 0; br_taken together with id_halt → halted stays 0.
- rst pulled low mid-flush with flush_cnt=1 and 2 pending writes → all state cleared at once; after release, flush_if=0 and pend_cnt=0.
